// File: rtl/ex_pkg.sv
// Shared types and constants for the multi-cycle execute stage.
// The op-class decode is kept here so it can be reused by other pipeline stages.
package ex_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_HOLD
  } state_t;

  typedef enum logic [1:0] {
    OP_ALU,
    OP_MUL,
    OP_DIV
  } op_class_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  function automatic op_class_t decode_class(input logic m_ext, input logic [2:0] funct3);
    if (!m_ext) return OP_ALU;
    if (!funct3[2]) return OP_MUL;
    return OP_DIV;
  endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle integer ALU; alt selects SUB and SRA.
module alu #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic            alt,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;

  assign shamt = b[SHW-1:0];

  always_comb begin
    y = '0;
    case (funct3)
      3'b000: y = alt ? a - b : a + b;
      3'b001: y = a << shamt;
      3'b010: y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      3'b011: y = {{(XLEN-1){1'b0}}, (a < b)};
      3'b100: y = a ^ b;
      3'b101: y = alt ? $unsigned($signed(a) >>> shamt) : a >> shamt;
      3'b110: y = a | b;
      3'b111: y = a & b;
    endcase
  end

endmodule

// File: rtl/branch.sv
// Conditional-branch comparator for BEQ/BNE/BLT/BGE/BLTU/BGEU.
module branch #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = (a == b);
      3'b001:  taken = (a != b);
      3'b100:  taken = ($signed(a) < $signed(b));
      3'b101:  taken = ($signed(a) >= $signed(b));
      3'b110:  taken = (a < b);
      3'b111:  taken = (a >= b);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_seq_div_iter.sv
// Iterative radix-2 restoring divider working on magnitudes, one quotient bit per cycle.
// done is asserted during the final iteration, with result already sign-corrected.
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic            is_signed,
  input  logic            is_rem,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  logic            busy;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] divisor;
  logic            neg_q;
  logic            neg_r;
  logic            want_rem;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            fits;
  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] rem_next;

  assign mag_a = (is_signed & a[XLEN-1]) ? -a : a;
  assign mag_b = (is_signed & b[XLEN-1]) ? -b : b;

  // Partial remainder never exceeds the divisor, so XLEN+1 bits hold the shifted value.
  always_comb begin
    shifted  = {rem, quo[XLEN-1]};
    diff     = shifted - {1'b0, divisor};
    fits     = ~diff[XLEN];
    rem_next = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_next = {quo[XLEN-2:0], fits};
  end

  assign done   = busy & (count == CW'(XLEN - 1));
  assign result = want_rem ? (neg_r ? -rem_next : rem_next)
                           : (neg_q ? -quo_next : quo_next);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      busy     <= 1'b0;
      count    <= '0;
      quo      <= '0;
      rem      <= '0;
      divisor  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      want_rem <= 1'b0;
    end else if (start) begin
      busy     <= 1'b1;
      count    <= '0;
      quo      <= mag_a;
      rem      <= '0;
      divisor  <= mag_b;
      neg_q    <= is_signed & (a[XLEN-1] ^ b[XLEN-1]);
      neg_r    <= is_signed & a[XLEN-1];
      want_rem <= is_rem;
    end else if (busy) begin
      quo   <= quo_next;
      rem   <= rem_next;
      count <= count + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/mux2.sv
// Two-input multiplexer used for operand selection.
module mux2 #(
  parameter int W = 32
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/ex_seq.sv
// Multi-cycle execute stage: single-cycle ALU/branch, fixed-latency multiply,
// iterative divide, with valid/ready on both sides and a redirect flush.
module ex_seq
  import ex_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic            src1_selector,
  input  logic            src2_selector,
  input  logic            is_branch_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ex_result,
  output logic            is_branched
);

  localparam int MCW = $clog2(MUL_LATENCY + 1) + 1;

  state_t            state;
  op_class_t         op_class;
  logic [MCW-1:0]    mul_count;
  logic [XLEN-1:0]   mul_q;
  logic [XLEN-1:0]   src1;
  logic [XLEN-1:0]   src2;
  logic [XLEN-1:0]   alu_y;
  logic              br_taken;
  logic              accept;
  logic              a_signed;
  logic              b_signed;
  logic [2*XLEN-1:0] a_wide;
  logic [2*XLEN-1:0] b_wide;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   mul_value;
  logic              div_signed;
  logic              div_rem;
  logic              div_by_zero;
  logic              div_ovf;
  logic              div_special;
  logic [XLEN-1:0]   special_value;
  logic              div_start;
  logic              div_done;
  logic [XLEN-1:0]   div_result;
  logic              unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:1]};

  mux2 #(.W(XLEN)) u_src1_mux (.sel(src1_selector), .a(rd1), .b(pc_plus4), .y(src1));
  mux2 #(.W(XLEN)) u_src2_mux (.sel(src2_selector), .a(rd2), .b(imm),      .y(src2));

  alu #(.XLEN(XLEN)) u_alu (.funct3(funct3), .alt(funct7[5]), .a(src1), .b(src2), .y(alu_y));

  branch #(.XLEN(XLEN)) u_branch (.funct3(funct3), .a(rd1), .b(rd2), .taken(br_taken));

  assign op_class  = decode_class(funct7[0], funct3);
  assign in_ready  = ((state == ST_IDLE) | ((state == ST_HOLD) & out_ready)) & ~flush;
  assign out_valid = (state == ST_HOLD);
  assign accept    = in_valid & in_ready;

  // Sign-extending both operands to 2*XLEN makes one multiplier serve all four variants.
  assign a_signed  = (funct3 == F3_MULH) | (funct3 == F3_MULHSU);
  assign b_signed  = (funct3 == F3_MULH);
  assign a_wide    = {{XLEN{a_signed & src1[XLEN-1]}}, src1};
  assign b_wide    = {{XLEN{b_signed & src2[XLEN-1]}}, src2};
  assign product   = a_wide * b_wide;
  assign mul_value = (funct3 == F3_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

  assign div_signed    = ~funct3[0];
  assign div_rem       = funct3[1];
  assign div_by_zero   = (src2 == '0);
  assign div_ovf       = div_signed & (src1 == {1'b1, {(XLEN-1){1'b0}}}) & (src2 == '1);
  assign div_special   = div_by_zero | div_ovf;
  assign special_value = div_by_zero ? (div_rem ? src1 : '1) : (div_rem ? '0 : src1);
  assign div_start     = accept & (op_class == OP_DIV) & ~div_special;

  div_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .start     (div_start),
    .is_signed (div_signed),
    .is_rem    (div_rem),
    .a         (src1),
    .b         (src2),
    .done      (div_done),
    .result    (div_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ex_result   <= '0;
      is_branched <= 1'b0;
      mul_count   <= '0;
      mul_q       <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      mul_count <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            case (op_class)
              OP_ALU: begin
                state       <= ST_HOLD;
                ex_result   <= alu_y;
                is_branched <= is_branch_op & br_taken;
              end
              OP_MUL: begin
                is_branched <= 1'b0;
                if (MUL_LATENCY == 1) begin
                  state     <= ST_HOLD;
                  ex_result <= mul_value;
                end else begin
                  state     <= ST_MUL;
                  mul_q     <= mul_value;
                  mul_count <= MCW'(1);
                end
              end
              OP_DIV: begin
                is_branched <= 1'b0;
                if (div_special) begin
                  state     <= ST_HOLD;
                  ex_result <= special_value;
                end else begin
                  state <= ST_DIV;
                end
              end
              default: state <= ST_IDLE;
            endcase
          end else if ((state == ST_HOLD) && out_ready) begin
            state <= ST_IDLE;
          end
        end
        ST_MUL: begin
          if (mul_count == MCW'(MUL_LATENCY - 1)) begin
            state     <= ST_HOLD;
            ex_result <= mul_q;
            mul_count <= '0;
          end else begin
            mul_count <= mul_count + MCW'(1);
          end
        end
        ST_DIV: begin
          if (div_done) begin
            state     <= ST_HOLD;
            ex_result <= div_result;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_seq.sv
// Scoreboard bench for ex_seq: a driver pushes reference-model results at accept,
// an independent monitor pops and compares them whenever a result is presented.
module tb_ex_seq;

  localparam int XLEN = 32;
  localparam int ML   = 2;

  typedef struct {
    logic [31:0] res;
    logic        br;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc_plus4;
  logic        src1_selector;
  logic        src2_selector;
  logic        is_branch_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] ex_result;
  logic        is_branched;

  exp_t sb[$];
  int   checks     = 0;
  int   errors     = 0;
  int   cycle      = 0;
  int   ready_mode = 0;
  bit   mon_en     = 1'b0;

  ex_seq #(.XLEN(XLEN), .MUL_LATENCY(ML)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .pc_plus4      (pc_plus4),
    .src1_selector (src1_selector),
    .src2_selector (src2_selector),
    .is_branch_op  (is_branch_op),
    .funct3        (funct3),
    .funct7        (funct7),
    .imm           (imm),
    .rd1           (rd1),
    .rd2           (rd2),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .ex_result     (ex_result),
    .is_branched   (is_branched)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    int sa = a;
    int sb2 = b;
    logic [4:0] sh = b[4:0];
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return (sa < sb2) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'(sa >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic br_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa = a;
    int sb2 = b;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb2;
      3'd5: return sa >= sb2;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model(input logic [2:0] f3, input logic [6:0] f7, input logic s1, input logic s2,
                       input logic isb, input logic [31:0] pc, input logic [31:0] im,
                       input logic [31:0] r1, input logic [31:0] r2, output exp_t e);
    logic [31:0] a;
    logic [31:0] b;
    int          ia;
    int          ib;
    longint      la;
    longint      lb;
    logic [63:0] p;
    a = s1 ? pc : r1;
    b = s2 ? im : r2;
    ia = a;
    ib = b;
    e.br = 1'b0;
    e.acc = cycle;
    if (!f7[0]) begin
      e.res = alu_ref(f3, f7[5], a, b);
      e.br  = isb && br_ref(f3, r1, r2);
      e.lat = 1;
    end else if (!f3[2]) begin
      e.lat = ML;
      la = ia;
      lb = {32'b0, b};
      case (f3[1:0])
        2'd0: begin e.res = a * b; end
        2'd1: begin lb = ib; p = la * lb; e.res = p[63:32]; end
        2'd2: begin p = la * lb; e.res = p[63:32]; end
        default: begin p = {32'b0, a} * {32'b0, b}; e.res = p[63:32]; end
      endcase
    end else begin
      if (b == 32'd0) begin
        e.res = f3[1] ? a : 32'hFFFF_FFFF;
        e.lat = 1;
      end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.res = f3[1] ? 32'd0 : a;
        e.lat = 1;
      end else begin
        e.lat = XLEN + 1;
        if (!f3[0]) e.res = f3[1] ? 32'(ia % ib) : 32'(ia / ib);
        else        e.res = f3[1] ? a % b : a / b;
      end
    end
  endtask

  // Presents one operation and holds it until the stage accepts it.
  task automatic applyStimulus(input logic [2:0] f3, input logic [6:0] f7, input logic s1,
                               input logic s2, input logic isb, input logic [31:0] pc,
                               input logic [31:0] im, input logic [31:0] r1, input logic [31:0] r2);
    int   waited = 0;
    exp_t e;
    @(negedge clk);
    funct3 = f3; funct7 = f7; src1_selector = s1; src2_selector = s2; is_branch_op = isb;
    pc_plus4 = pc; imm = im; rd1 = r1; rd2 = r2; in_valid = 1'b1;
    #1;
    while (!in_ready) begin
      if (waited > 300) begin
        checks++; errors++;
        $display("[TB] FAIL accept_timeout: in_ready stayed 0, required 1 within 300 cycles");
        in_valid = 1'b0;
        return;
      end
      waited++;
      @(negedge clk); #1;
    end
    model(f3, f7, s1, s2, isb, pc, im, r1, r2, e);
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("[TB] FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      4: return 32'(0 - $urandom_range(1, 20));
      default: return $urandom();
    endcase
  endfunction

  // Downstream ready pattern: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    forever begin
      @(negedge clk);
      case (ready_mode)
        0: out_ready = 1'b1;
        2: out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: compare every presented result against the oldest expectation.
  initial begin
    exp_t e;
    bit   prev_valid = 1'b0;
    bit   prev_hs    = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (mon_en) begin
        if (out_valid) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL unexpected_result: got out_valid=1 result 0x%08h, required out_valid=0", ex_result);
          end else begin
            e = sb[0];
            if (!prev_valid || prev_hs) checkOutput("latency", 32'(cycle - e.acc), 32'(e.lat));
            checkOutput("ex_result", ex_result, e.res);
            checkOutput("is_branched", {31'b0, is_branched}, {31'b0, e.br});
            if (out_ready && !flush) void'(sb.pop_front());
          end
        end
        prev_valid = out_valid;
        prev_hs    = out_valid && out_ready && !flush;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int t;
    logic [2:0] f3;
    logic [6:0] f7;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1;
    funct3 = 3'd0; funct7 = 7'd0; src1_selector = 1'b0; src2_selector = 1'b0;
    is_branch_op = 1'b0; pc_plus4 = 32'd0; imm = 32'd0; rd1 = 32'd1; rd2 = 32'd2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_ex_result", ex_result, 32'd0);
    checkOutput("reset_is_branched", {31'b0, is_branched}, 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    checkOutput("in_ready_after_reset", {31'b0, in_ready}, 32'd1);
    mon_en = 1'b1;

    ready_mode = 0;
    applyStimulus(3'b000, 7'h00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd5, 32'd7);
    applyStimulus(3'b000, 7'h20, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd5, 32'd7);
    applyStimulus(3'b000, 7'h00, 1'b0, 1'b1, 1'b1, 32'h100, 32'h40, 32'd3, 32'd3);

    applyStimulus(3'b001, 7'h01, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h8000_0000, 32'h8000_0000);
    @(negedge clk); #1;
    checkOutput("in_ready_during_mul", {31'b0, in_ready}, 32'd0);
    applyStimulus(3'b011, 7'h01, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd2);

    applyStimulus(3'b100, 7'h01, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFF9, 32'd2);
    applyStimulus(3'b110, 7'h01, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFF9, 32'd2);
    applyStimulus(3'b101, 7'h01, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd100, 32'd7);

    applyStimulus(3'b101, 7'h01, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd12345, 32'd0);
    applyStimulus(3'b110, 7'h01, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd9, 32'd0);
    applyStimulus(3'b100, 7'h01, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus(3'b110, 7'h01, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF);
    waitIdle();

    // Downstream stalls for five cycles once the result appears.
    ready_mode = 2;
    applyStimulus(3'b101, 7'h01, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd1000, 32'd33);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    repeat (5) begin
      @(negedge clk); #1;
      checkOutput("stall_out_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("stall_in_ready", {31'b0, in_ready}, 32'd0);
    end
    ready_mode = 0;
    waitIdle();

    // Flush in the middle of a divide, with a competing operation presented.
    applyStimulus(3'b100, 7'h01, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; funct3 = 3'b000; funct7 = 7'h00;
    src1_selector = 1'b0; src2_selector = 1'b0; rd1 = 32'd1; rd2 = 32'd1;
    #1;
    checkOutput("in_ready_during_flush", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk); #1;
    checkOutput("flush_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("flush_idle_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (40) @(posedge clk);
    applyStimulus(3'b000, 7'h00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd20, 32'd22);
    waitIdle();

    // Randomised mix of all operation classes under random backpressure.
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 2))
        0: begin f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
        default: begin f7 = 7'h01; end
      endcase
      f3 = 3'($urandom_range(0, 7));
      applyStimulus(f3, f7, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), pick(), pick(), pick(), pick());
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    ready_mode = 0;
    waitIdle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_seq.md
# ex_seq

Multi-cycle execute stage: the successor to the single-cycle execute stage, generalised to XLEN width. It keeps the ALU and branch paths single-cycle, retires multiplies after a configurable latency and runs divides/remainders on an iterative radix-2 divider. It sits between decode and writeback with a valid/ready handshake on both sides, so the pipeline stalls while a long operation is in flight. It also supports a flush for branch/trap redirects.

## Interface
- XLEN, 32: datapath width, ≥8, even.
- MUL_LATENCY, 2: cycles from accept to out_valid for MUL/MULH/MULHSU/MULHU, ≥1.

- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  abort in-flight op, drop held result.
- in_valid  in  1  operation presented.
- in_ready  out  1  stage can accept this cycle.
- pc_plus4  in  XLEN  src1 alternative.
- src1_selector, src2_selector  in  1 each  0: rd1/rd2, 1: pc_plus4/imm.
- is_branch_op  in  1  operation is a conditional branch.
- funct3  in  3  RV funct3.
- funct7  in  7  RV funct7; bit0 selects M-extension.
- imm, rd1, rd2  in  XLEN each  immediate and register operands.
- out_valid  out  1  result held for downstream.
- out_ready  in  1  downstream consumes result.
- ex_result  out  XLEN  result.
- is_branched  out  1  branch taken (is_branch_op & condition).

## Operation
- Accept when in_valid & in_ready. Latch src1, src2, rd1, rd2, funct3, funct7[0] and is_branch_op at accept; input ports are don't-care afterwards.
- src1 = src1_selector ? pc_plus4 : rd1. src2 = src2_selector ? imm : rd2. The branch comparison always uses rd1/rd2.
- Class decode: funct7[0]=0 is ALU; funct7[0]=1 with funct3[2]=0 is MUL; funct7[0]=1 with funct3[2]=1 is DIV.
- FSM states:
  - IDLE to HOLD on accept of ALU, or of DIV with a special case.
  - IDLE to MUL on MUL accept. MUL to HOLD when its counter reaches MUL_LATENCY-1. With MUL_LATENCY=1, IDLE goes straight to HOLD.
  - IDLE to DIV on normal DIV accept. DIV to HOLD after XLEN iterations.
  - HOLD to IDLE on out_ready. HOLD to MUL/DIV/HOLD on out_ready with a simultaneous accept.
- in_ready = (state==IDLE) | (state==HOLD & out_ready); forced 0 during flush.
- out_valid = (state==HOLD). ex_result and is_branched are stable while out_valid=1 and out_ready=0.
- MUL results: low XLEN (MUL) or high XLEN of the 2·XLEN signed/unsigned product (MULH/MULHSU/MULHU).
- DIV: restoring, one quotient bit per cycle on magnitudes; signs fixed up at the end (quotient sign = sign a ^ sign b, remainder sign = sign a).
- DIV special cases, resolved at accept, never enter DIV:
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - Signed overflow (-2^(XLEN-1) / -1): DIV gives the dividend; REM gives 0.
- is_branched = 0 for non-branch ops, and for MUL/DIV ops.
- flush: the next state is IDLE, counters clear, and out_valid=0 next cycle. An accept in the same cycle is ignored. flush has priority over out_ready.
- Reset, or flush, mid-divide discards partial state; no result is produced.

## Timing
- Reset values: out_valid=0, ex_result=0, is_branched=0, state=IDLE. in_ready=1 in the first cycle after reset is released.
- Latency, accept cycle T to out_valid first high:
  - ALU, branch and DIV special cases: T+1.
  - MUL: T+MUL_LATENCY.
  - Normal DIV: T+XLEN+1.
- Throughput: one ALU op per cycle when out_ready is held at 1.
- out_valid stays high until the cycle out_ready=1, inclusive.

## Structure
- Shared package ex_pkg holds:
  - the state enum (IDLE, MUL, DIV, HOLD);
  - the op-class enum;
  - funct3 localparams for MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Reuse the existing alu, branch and mux2 modules unchanged.
- The multiplier is behavioural, 2·XLEN wide; its output is registered at accept and counted through the MUL state.
- One sub-module: div_iter (XLEN param).
  - Inputs: start, signed flag, rem flag, a, b, flush/rst_n.
  - Outputs: done and result.
  - Holds the quotient/remainder shift registers and a $clog2(XLEN)+1 counter.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, ex_result=0. in_ready=1 in the first cycle after release.
- ALU back-to-back with out_ready=1, XLEN=32: ADD 5+7, then SUB 5-7 -> results 12 then 0xFFFFFFFE on consecutive cycles. BEQ with rd1=rd2=3 -> is_branched=1.
- MUL, MUL_LATENCY=2: MULH 0x80000000 × 0x80000000 -> 0x40000000 at T+2. MULHU 0xFFFFFFFF × 2 -> 1. in_ready=0 during the MUL state.
- DIV: DIV -7/2 -> 0xFFFFFFFD at T+33. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14.
- Special cases at T+1:
  - DIVU x/0 -> 0xFFFFFFFF;
  - REM 9/0 -> 9;
  - DIV 0x80000000/-1 -> 0x80000000;
  - REM 0x80000000/-1 -> 0.
- Backpressure and flush:
  - out_ready=0 for 5 cycles after the result -> result and out_valid held, in_ready=0.
  - flush at iteration 10 of a divide -> out_valid never rises, IDLE next cycle.
  - A new ADD then completes at T+1.
